uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one UART byte transmitter among `NUM_REQ` requesters. It accepts bytes from the requesters over a valid/ready handshake and launches them one at a time with a start pulse. It tracks the transmitter's busy flag to detect end of frame and enforces a minimum inter-byte gap. A requester can hold the transmitter for a multi-byte message until it marks the last byte; a hold timeout prevents a stalled owner from starving the others.

---
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signal bundle shared by uart_tx_arbiter and its environment.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 tx_start;
  logic [7:0]           tx_byte;
  logic                 tx_busy;
  logic                 idle;

  // master: requesters and the byte transmitter
  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, grant, tx_start, tx_byte, idle
  );

  // slave: the arbiter itself
  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, grant, tx_start, tx_byte, idle
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among NUM_REQ requesters,
// with locked multi-byte messages, inter-byte gap and owner hold timeout.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned HOLD_MAX   = 1024
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int unsigned IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CAND_W    = IDX_W + 1;
  localparam int unsigned HOLD_W    = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam int unsigned GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned HOLD_LAST = (HOLD_MAX > 0) ? HOLD_MAX - 1 : 0;
  localparam int unsigned GAP_LAST  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               last_q, last_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic               start_q, start_d;
  logic [7:0]         byte_q, byte_d;
  logic               idle_q, idle_d;

  logic               pick_found_c;
  logic [IDX_W-1:0]   pick_idx_c;
  logic [CAND_W-1:0]  cand_c;
  logic [IDX_W-1:0]   owner_inc_c;
  logic               frame_end_c;

  assign bus.req_ready = ready_q;
  assign bus.grant     = grant_q;
  assign bus.tx_start  = start_q;
  assign bus.tx_byte   = byte_q;
  assign bus.idle      = idle_q;

  assign owner_inc_c = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

  // First valid requester searching upward from ptr, wrapping at NUM_REQ
  always_comb begin
    pick_found_c = 1'b0;
    pick_idx_c   = '0;
    cand_c       = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      cand_c = {1'b0, ptr_q} + CAND_W'(k);
      if (cand_c >= CAND_W'(NUM_REQ)) cand_c = cand_c - CAND_W'(NUM_REQ);
      if (!pick_found_c && bus.req_valid[cand_c[IDX_W-1:0]]) begin
        pick_found_c = 1'b1;
        pick_idx_c   = cand_c[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      gap_q   <= '0;
      last_q  <= 1'b0;
      grant_q <= '0;
      ready_q <= '0;
      start_q <= 1'b0;
      byte_q  <= 8'h00;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      ready_q <= ready_d;
      start_q <= start_d;
      byte_q  <= byte_d;
      idle_q  <= idle_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    gap_d       = gap_q;
    last_d      = last_q;
    grant_d     = grant_q;
    ready_d     = ready_q;
    start_d     = 1'b0;
    byte_d      = byte_q;
    idle_d      = 1'b0;
    frame_end_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_found_c) begin
          owner_d             = pick_idx_c;
          grant_d             = '0;
          grant_d[pick_idx_c] = 1'b1;
          ready_d             = '0;
          ready_d[pick_idx_c] = 1'b1;
          hold_d              = '0;
          state_d             = S_SEND;
        end
      end
      S_SEND: begin
        if (bus.req_valid[owner_q]) begin
          byte_d  = bus.req_data[{owner_q, 3'b000} +: 8];
          last_d  = bus.req_last[owner_q];
          start_d = 1'b1;
          ready_d = '0;
          state_d = S_WAIT_BUSY;
        end else if (hold_q == HOLD_W'(HOLD_LAST)) begin
          // stalled owner loses the transmitter to the next requester in line
          grant_d = '0;
          ready_d = '0;
          hold_d  = '0;
          ptr_d   = owner_inc_c;
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_WAIT_BUSY: begin
        if (bus.tx_busy) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          gap_d = '0;
          if (GAP_CYCLES == 0) frame_end_c = 1'b1;
          else                 state_d     = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_LAST)) frame_end_c = 1'b1;
        else                           gap_d       = gap_q + GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // after the gap: release the bus on the last byte, otherwise keep the lock
    if (frame_end_c) begin
      if (last_q) begin
        grant_d = '0;
        ready_d = '0;
        ptr_d   = owner_inc_c;
        state_d = S_IDLE;
      end else begin
        ready_d = grant_q;
        hold_d  = '0;
        state_d = S_SEND;
      end
    end

    idle_d = (state_d == S_IDLE);
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: queued requester messages, a message-level round-robin model,
// and a monitor that checks every tx_start against the expected (owner, byte) stream.
module tb_uart_tx_arbiter;
  localparam int NR     = 4;
  localparam int GAP_A  = 16;
  localparam int HOLD_A = 1024;
  localparam int HOLD_B = 8;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic reset;

  int total = 0;
  int bad   = 0;
  int m_ptr = 0;
  int tx_len = 0;

  exp_t  exp_q[$];
  beat_t drv_q[NR][$];
  beat_t mdl_q[NR][$];

  initial forever #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus_a ();
  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus_b ();

  uart_tx_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(GAP_A), .HOLD_MAX(HOLD_A)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  uart_tx_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(0), .HOLD_MAX(HOLD_B)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic add_beat(input int id, input logic [7:0] d, input logic last);
    beat_t b;
    b.last = last;
    b.data = d;
    drv_q[id].push_back(b);
    mdl_q[id].push_back(b);
  endtask

  // Message-level reference: whole messages granted round-robin from the model pointer
  task automatic model_run();
    int   id;
    beat_t b;
    exp_t e;
    forever begin
      id = -1;
      for (int k = 0; k < NR; k++)
        if (id < 0 && mdl_q[(m_ptr + k) % NR].size() > 0) id = (m_ptr + k) % NR;
      if (id < 0) break;
      do begin
        b = mdl_q[id].pop_front();
        e.id   = 2'(id);
        e.data = b.data;
        exp_q.push_back(e);
      end while (!b.last && mdl_q[id].size() > 0);
      m_ptr = (id + 1) % NR;
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++) if (drv_q[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_all();
    exp_q.delete();
    for (int i = 0; i < NR; i++) begin
      drv_q[i].delete();
      mdl_q[i].delete();
    end
    m_ptr = 0;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while (n < limit && !(exp_q.size() == 0 && bus_a.idle && all_empty())) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 32'(n < limit), 32'd1);
    if (n >= limit) exp_q.delete();
  endtask

  // Requester driver for DUT A: present queue heads, pop on accepted handshake
  initial begin
    logic [NR-1:0] acc;
    bus_a.req_valid = '0;
    bus_a.req_data  = '0;
    bus_a.req_last  = '0;
    forever begin
      @(negedge clk);
      acc = bus_a.req_valid & bus_a.req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (acc[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
        if (drv_q[i].size() > 0) begin
          bus_a.req_valid[i]        = 1'b1;
          bus_a.req_data[8*i +: 8]  = drv_q[i][0].data;
          bus_a.req_last[i]         = drv_q[i][0].last;
        end else begin
          bus_a.req_valid[i] = 1'b0;
          bus_a.req_last[i]  = 1'b0;
        end
      end
    end
  end

  // Transmitter model for DUT A: busy after 0..2 cycles, for tx_len (or random) cycles
  initial begin
    int d;
    int len;
    bus_a.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_a.tx_start) begin
        d = (tx_len > 0) ? 0 : int'($urandom_range(0, 2));
        repeat (d) @(negedge clk);
        bus_a.tx_busy = 1'b1;
        len = (tx_len > 0) ? tx_len : int'($urandom_range(3, 12));
        repeat (len) @(negedge clk);
        bus_a.tx_busy = 1'b0;
      end
    end
  end

  // Transmitter model for DUT B: busy rises in the same cycle as tx_start
  initial begin
    bus_b.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_b.tx_start) begin
        bus_b.tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        bus_b.tx_busy = 1'b0;
      end
    end
  end

  // Scoreboard monitor for DUT A
  initial begin
    exp_t e;
    logic prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_start = 1'b0;
      end else begin
        if (bus_a.tx_start) begin
          chk("start_single_cycle", 32'(prev_start), 32'd0);
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_start", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            chk("sb_grant", 32'(bus_a.grant), 32'd1 << e.id);
            chk("sb_byte", 32'(bus_a.tx_byte), 32'(e.data));
          end
        end
        if (bus_a.req_ready != '0)
          chk("ready_owner_only", 32'(bus_a.req_ready & ~bus_a.grant), 32'd0);
        if (bus_a.idle) chk("idle_no_grant", 32'(bus_a.grant), 32'd0);
        prev_start = bus_a.tx_start;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  seen;
    bit  early;
    logic b;

    reset = 1'b1;
    bus_b.req_valid = '0;
    bus_b.req_data  = '0;
    bus_b.req_last  = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_grant", 32'(bus_a.grant), 32'd0);
    chk("rst_ready", 32'(bus_a.req_ready), 32'd0);
    chk("rst_start", 32'(bus_a.tx_start), 32'd0);
    chk("rst_byte", 32'(bus_a.tx_byte), 32'd0);
    chk("rst_idle", 32'(bus_a.idle), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // single byte from requester 2 with a 20-cycle frame
    tx_len = 20;
    add_beat(2, 8'hA5, 1'b1);
    model_run();
    n = 0;
    do begin @(posedge clk); #2; n++; end while (!bus_a.req_valid[2] && n < 20);
    chk("single_grant_latency", 32'(bus_a.grant), 32'd0);
    @(posedge clk); #2;
    chk("single_grant", 32'(bus_a.grant), 32'b0100);
    chk("single_ready", 32'(bus_a.req_ready), 32'b0100);
    n = 0;
    while (!bus_a.tx_busy && n < 100) begin @(posedge clk); n++; end
    while (bus_a.tx_busy && n < 200) begin @(posedge clk); n++; end
    #1;
    n = 1;
    while (!bus_a.idle && n < 200) begin @(posedge clk); #1; n++; end
    chk("single_idle_after_gap", 32'(n), 32'(GAP_A + 1));
    wait_drain("single_drain", 200);
    tx_len = 0;

    // pointer now past requester 2: requester 3 beats requester 0
    add_beat(0, 8'h10, 1'b1);
    add_beat(3, 8'h30, 1'b1);
    model_run();
    wait_drain("ptr_drain", 500);

    // round-robin from index 0 after reset
    @(posedge clk); #3;
    reset = 1'b1;
    clear_all();
    @(negedge clk);
    reset = 1'b0;
    add_beat(0, 8'hC0, 1'b1);
    add_beat(0, 8'hC4, 1'b1);
    add_beat(1, 8'hC1, 1'b1);
    add_beat(2, 8'hC2, 1'b1);
    add_beat(3, 8'hC3, 1'b1);
    model_run();
    wait_drain("rr_drain", 1000);

    // locked three-byte message while requester 0 waits
    add_beat(0, 8'h44, 1'b1);
    add_beat(1, 8'h11, 1'b0);
    add_beat(1, 8'h22, 1'b0);
    add_beat(1, 8'h33, 1'b1);
    model_run();
    wait_drain("lock_drain", 1000);

    // hold timeout: requester 3 stalls mid-message
    add_beat(0, 8'h55, 1'b1);
    add_beat(3, 8'h01, 1'b0);
    model_run();
    n = 0;
    while (!bus_a.tx_start && n < 100) begin @(posedge clk); #1; n++; end
    chk("hold_first_start", 32'(bus_a.grant), 32'b1000);
    n = 0;
    do begin
      @(posedge clk); #1;
      if (bus_a.grant[3] && bus_a.req_ready[3]) n++;
    end while (bus_a.grant[3] && n < 3000);
    chk("hold_send_cycles", 32'(n), 32'(HOLD_A));
    wait_drain("hold_drain", 500);

    // randomized message mixes
    for (int r = 0; r < 6; r++) begin
      int cnt = 0;
      for (int i = 0; i < NR; i++) begin
        int nmsg = int'($urandom_range(0, 2));
        for (int m = 0; m < nmsg; m++) begin
          int len = int'($urandom_range(1, 3));
          for (int j = 0; j < len; j++) begin
            add_beat(i, 8'($urandom), 1'(j == len - 1));
            cnt++;
          end
        end
      end
      if (cnt == 0) add_beat(int'($urandom_range(0, NR - 1)), 8'($urandom), 1'b1);
      model_run();
      wait_drain("rand_drain", 5000);
    end

    // reset while the transmitter frame is in progress
    add_beat(2, 8'h77, 1'b1);
    model_run();
    n = 0;
    while (!bus_a.tx_start && n < 100) begin @(posedge clk); #1; n++; end
    while (!bus_a.tx_busy && n < 200) begin @(posedge clk); n++; end
    @(posedge clk); #3;
    reset = 1'b1;
    clear_all();
    #1;
    chk("midrst_grant", 32'(bus_a.grant), 32'd0);
    chk("midrst_ready", 32'(bus_a.req_ready), 32'd0);
    chk("midrst_start", 32'(bus_a.tx_start), 32'd0);
    chk("midrst_byte", 32'(bus_a.tx_byte), 32'd0);
    chk("midrst_idle", 32'(bus_a.idle), 32'd1);
    n = 0;
    while (bus_a.tx_busy && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    reset = 1'b0;
    add_beat(3, 8'h83, 1'b1);
    add_beat(1, 8'h81, 1'b1);
    model_run();
    wait_drain("midrst_drain", 500);

    // DUT B: zero gap, busy in the same cycle as tx_start
    @(negedge clk);
    bus_b.req_data  = 32'h0000_B100;
    bus_b.req_last  = 4'b0000;
    bus_b.req_valid = 4'b0010;
    n = 0;
    while (!bus_b.tx_start && n < 50) begin @(posedge clk); #1; n++; end
    chk("b_byte0", 32'(bus_b.tx_byte), 32'h0000_00B1);
    chk("b_grant0", 32'(bus_b.grant), 32'b0010);
    bus_b.req_valid = 4'b0000;
    seen  = 1'b0;
    early = 1'b0;
    n = 0;
    forever begin
      @(posedge clk);
      b = bus_b.tx_busy;
      #1;
      n++;
      if (b) begin
        seen  = 1'b1;
        early = early | (|bus_b.req_ready);
      end else if (seen || n > 50) begin
        break;
      end
    end
    chk("b_ready_not_early", 32'(early), 32'd0);
    chk("b_ready_after_busy", 32'(bus_b.req_ready), 32'b0010);
    bus_b.req_data  = 32'h0000_B200;
    bus_b.req_last  = 4'b0010;
    bus_b.req_valid = 4'b0010;
    n = 0;
    while (!bus_b.tx_start && n < 50) begin @(posedge clk); #1; n++; end
    chk("b_byte1", 32'(bus_b.tx_byte), 32'h0000_00B2);
    bus_b.req_valid = 4'b0000;
    bus_b.req_last  = 4'b0000;
    n = 0;
    while (!bus_b.idle && n < 50) begin @(posedge clk); #1; n++; end
    chk("b_idle_after_last", 32'(bus_b.idle), 32'd1);
    chk("b_grant_released", 32'(bus_b.grant), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
